instr_fetch_unit: RTL and testbench

Fetch stage of the single-cycle MIPS core: owns the program counter, fetches 16-bit instructions from instruction memory over a req/ack handshake, and holds the current instruction stable for the controller and datapath until the core commits it. Sits directly upstream of the controller. It consumes the controller's jump select (`pcSrc`) and taken-branch select (`branchPcSrc`) to form the next PC.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/pc_next_sel.sv | 42 ++++
 rtl/instr_fetch_unit.sv | 69 ++++++
 tb/tb_instr_fetch_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM encoding, instruction
// field positions used for jump/branch targets, and default widths.
package fetch_pkg;

  localparam int DEF_PC_W    = 12;
  localparam int DEF_INSTR_W = 16;

  localparam int JUMP_LSB   = 0;
  localparam int JUMP_MSB   = 11;
  localparam int BR_OFF_LSB = 0;
  localparam int BR_OFF_MSB = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: jump target beats taken branch beats pc+1.
// All arithmetic wraps modulo 2^PC_W.
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] ir_i,
  input  logic               pc_src_i,
  input  logic               br_pc_src_i,
  output logic [PC_W-1:0]    pc_next_o
);

  localparam int JW = JUMP_MSB - JUMP_LSB + 1;
  localparam int BW = BR_OFF_MSB - BR_OFF_LSB + 1;

  logic [JW-1:0]        jfield;
  logic signed [BW-1:0] boff;
  logic [PC_W-1:0]      pc_inc;
  logic [PC_W-1:0]      jmp_tgt;
  logic [PC_W-1:0]      br_tgt;
  logic                 unused_hi;

  assign jfield = ir_i[JUMP_MSB:JUMP_LSB];
  assign boff   = ir_i[BR_OFF_MSB:BR_OFF_LSB];

  // Jump field is unsigned (zero-extend); branch offset is signed (sign-extend).
  assign pc_inc  = pc_i + PC_W'(1);
  assign jmp_tgt = PC_W'(jfield);
  assign br_tgt  = pc_inc + PC_W'(boff);

  assign unused_hi = ^ir_i[INSTR_W-1:JUMP_MSB+1];

  always_comb begin
    pc_next_o = pc_inc;
    if (pc_src_i)         pc_next_o = jmp_tgt;
    else if (br_pc_src_i) pc_next_o = br_tgt;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC and the instruction register, fetches over a
// req/ack handshake and holds the instruction until the core commits it.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = DEF_PC_W,
  parameter int              INSTR_W  = DEF_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  input  logic               commit,
  input  logic               pcSrc,
  input  logic               branchPcSrc,
  output logic [PC_W-1:0]    pc
);

  fetch_state_e       state_q;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_d;
  logic [INSTR_W-1:0] ir_q;

  pc_next_sel #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_pc_next_sel (
    .pc_i        (pc_q),
    .ir_i        (ir_q),
    .pc_src_i    (pcSrc),
    .br_pc_src_i (branchPcSrc),
    .pc_next_o   (pc_d)
  );

  // Stray commit/ack are filtered simply by only looking at them in their state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      case (state_q)
        IDLE:  state_q <= FETCH;
        FETCH: if (imem_ack) begin
                 ir_q    <= imem_rdata;
                 state_q <= VALID;
               end
        VALID: if (commit) begin
                 pc_q    <= pc_d;
                 state_q <= FETCH;
               end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode registered state only.
  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == VALID);
  assign instruction = ir_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboarded bench for instr_fetch_unit: directed program with a wait-state
// memory model; a monitor checks each fetch address and each captured instruction.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        commit = 1'b0;
  logic        pcSrc = 1'b0;
  logic        branchPcSrc = 1'b0;
  logic [11:0] pc;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .commit      (commit),
    .pcSrc       (pcSrc),
    .branchPcSrc (branchPcSrc),
    .pc          (pc)
  );

  // Memory model: ack after wait_n FETCH cycles; ack_force injects a stray ack.
  logic [15:0] mem [0:4095];
  int          wcnt = 0;
  int          wait_n = 0;
  logic        ack_force = 1'b0;

  always @(posedge clk) begin
    if (!imem_req) wcnt <= 0;
    else           wcnt <= wcnt + 1;
  end

  assign imem_ack   = (imem_req && (wcnt >= wait_n)) || ack_force;
  assign imem_rdata = ack_force ? 16'hDEAD : mem[imem_addr];

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_addr_q[$];
  logic [27:0] exp_instr_q[$];

  typedef struct {
    logic [11:0] pc;
    logic [15:0] ir;
    int          waitn;
    bit          jmp;
    bit          br;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic        pr = 1'b0;
    logic        pv = 1'b0;
    logic [11:0] faddr = '0;
    logic [11:0] ea;
    logic [27:0] ei;
    forever begin
      @(negedge clk);
      if (imem_req && !pr) begin
        faddr = imem_addr;
        if (exp_addr_q.size() == 0) chk("sb_addr_unexpected", 32'(imem_addr), 32'hFFFF_FFFF);
        else begin
          ea = exp_addr_q.pop_front();
          chk("sb_fetch_addr", 32'(imem_addr), 32'(ea));
        end
      end else if (imem_req) begin
        chk("addr_stable", 32'(imem_addr), 32'(faddr));
      end
      if (instr_valid && !pv) begin
        if (exp_instr_q.size() == 0) chk("sb_instr_unexpected", 32'({pc, instruction}), 32'hFFFF_FFFF);
        else begin
          ei = exp_instr_q.pop_front();
          chk("sb_pc_instr", 32'({pc, instruction}), 32'(ei));
        end
      end
      pr = imem_req;
      pv = instr_valid;
    end
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!instr_valid && cnt < 60) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!instr_valid) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout actual=0 expected=1");
    end
  endtask

  initial begin
    int cnt;
    vecs[0]  = '{12'h000, 16'h1234, 0, 1'b0, 1'b0};
    vecs[1]  = '{12'h001, 16'h0005, 0, 1'b1, 1'b0};
    vecs[2]  = '{12'h005, 16'hA005, 0, 1'b0, 1'b0};
    vecs[3]  = '{12'h006, 16'h000A, 3, 1'b1, 1'b0};
    vecs[4]  = '{12'h00A, 16'h00FC, 0, 1'b0, 1'b1};
    vecs[5]  = '{12'h007, 16'h03A0, 1, 1'b1, 1'b0};
    vecs[6]  = '{12'h3A0, 16'h0FFF, 0, 1'b1, 1'b1};
    vecs[7]  = '{12'hFFF, 16'h0FFE, 2, 1'b0, 1'b0};
    vecs[8]  = '{12'h000, 16'h1234, 0, 1'b1, 1'b0};
    vecs[9]  = '{12'h234, 16'h0FFE, 0, 1'b1, 1'b0};
    vecs[10] = '{12'hFFE, 16'h0001, 0, 1'b0, 1'b1};
    vecs[11] = '{12'h000, 16'h1234, 0, 1'b0, 1'b0};
    for (int a = 0; a < 4096; a++) mem[a] = '0;
    for (int i = 0; i < 12; i++) mem[vecs[i].pc] = vecs[i].ir;

    fork
      monitor();
    join_none

    // Reset state
    @(posedge clk); #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ir", 32'(instruction), 32'd0);

    exp_addr_q.push_back(12'h000);
    exp_instr_q.push_back({12'h000, 16'h1234});
    @(posedge clk); #1;
    rst = 1'b1;
    chk("cyc1_req", 32'(imem_req), 32'd0);
    @(posedge clk); #1;
    chk("cyc2_req", 32'(imem_req), 32'd1);
    chk("cyc2_addr", 32'(imem_addr), 32'd0);
    @(posedge clk); #1;
    chk("cyc3_valid", 32'(instr_valid), 32'd1);

    // Directed program: each row's commit controls lead to the next row's pc.
    for (int i = 0; i < 12; i++) begin
      wait_valid(cnt);
      if (i > 0) chk("latency", 32'(cnt), 32'(vecs[i].waitn + 1));
      if (i == 11) break;
      exp_addr_q.push_back(vecs[i+1].pc);
      exp_instr_q.push_back({vecs[i+1].pc, vecs[i+1].ir});
      wait_n = vecs[i+1].waitn;
      commit = 1'b1;
      pcSrc = vecs[i].jmp;
      branchPcSrc = vecs[i].br;
      @(posedge clk); #1;
      commit = 1'b0;
      pcSrc = 1'b0;
      branchPcSrc = 1'b0;
      chk("next_pc", 32'(pc), 32'(vecs[i+1].pc));
      chk("fetch_after_commit", 32'(imem_req), 32'd1);
    end

    // Stray ack during VALID must not disturb IR.
    ack_force = 1'b1;
    @(posedge clk); #1;
    ack_force = 1'b0;
    chk("stray_ack_ir", 32'(instruction), 32'h1234);
    chk("stray_ack_valid", 32'(instr_valid), 32'd1);

    // Stray commit/pcSrc during FETCH must not move the PC.
    wait_n = 5;
    exp_addr_q.push_back(12'h001);
    exp_instr_q.push_back({12'h001, 16'h0005});
    commit = 1'b1;
    @(posedge clk); #1;
    commit = 1'b1;
    pcSrc = 1'b1;
    @(posedge clk); #1;
    commit = 1'b0;
    pcSrc = 1'b0;
    chk("stray_commit_pc", 32'(pc), 32'h001);
    chk("stray_commit_req", 32'(imem_req), 32'd1);
    wait_valid(cnt);
    chk("after_stray_ir", 32'(instruction), 32'h0005);

    // Reset while waiting for ack.
    wait_n = 20;
    exp_addr_q.push_back(12'h005);
    commit = 1'b1;
    pcSrc = 1'b1;
    @(posedge clk); #1;
    commit = 1'b0;
    pcSrc = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_pc", 32'(pc), 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_ir", 32'(instruction), 32'd0);
    @(posedge clk); #1;
    exp_addr_q.push_back(12'h000);
    exp_instr_q.push_back({12'h000, 16'h1234});
    wait_n = 0;
    rst = 1'b1;
    chk("rerel_idle_req", 32'(imem_req), 32'd0);
    wait_valid(cnt);
    chk("rerel_cycles", 32'(cnt), 32'd2);
    chk("rerel_pc", 32'(pc), 32'd0);
    chk("rerel_ir", 32'(instruction), 32'h1234);

    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("sb_addr_drained", 32'(exp_addr_q.size()), 32'd0);
    chk("sb_instr_drained", 32'(exp_instr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
